mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port synchronous instruction/data RAM between the fetch path and the load/store path.
//  Grants one requester per cycle and routes each read result back to its owner one cycle later.
//  Exports fetch_stall so the pipeline control deasserts PC and FD-register write enables while fetch is denied.
//  Sits between the core pipeline and the RAM instance.
// PARAMETERS
//  ADDR_W      30  word-address width (byte address [31:2])
//  DATA_W      32  data width; byte enables are DATA_W/8 bits wide
//  MAX_STARVE  3   consecutive fetch denials after which fetch wins once over data
// PORTS
//  clk          in   1        rising-edge clock
//  reset_n      in   1        synchronous, active-low reset
//  if_req       in   1        fetch read request; held until if_gnt
//  if_addr      in   ADDR_W   fetch word address; stable while if_req=1
//  if_gnt       out  1        fetch accepted this cycle (combinational)
//  if_rvalid    out  1        if_rdata valid (registered, 1 cycle after if_gnt)
//  if_rdata     out  DATA_W   fetched instruction word
//  dm_req       in   1        data request; held until dm_gnt
//  dm_we        in   1        1=write, 0=read
//  dm_addr      in   ADDR_W   data word address
//  dm_wdata     in   DATA_W   store data
//  dm_be        in   DATA_W/8 store byte enables
//  dm_gnt       out  1        data access accepted this cycle (combinational)
//  dm_rvalid    out  1        dm_rdata valid (reads only, 1 cycle after dm_gnt)
//  dm_rdata     out  DATA_W   load data
//  ram_addr     out  ADDR_W   RAM address (muxed)
//  ram_wren     out  1        RAM write strobe
//  ram_byteena  out  DATA_W/8 RAM byte enables
//  ram_data     out  DATA_W   RAM write data
//  ram_q        in   DATA_W   RAM read data (1-cycle latency after ram_addr)
//  fetch_stall  out  1        if_req & ~if_gnt
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): rd_owner=NONE, starve_cnt=0; the next cycle shows if_rvalid=dm_rvalid=0.
//    A read granted in the reset cycle returns no rvalid. Grants are forced to 0 while reset_n=0.
//  - Arbitration each cycle (combinational):
//    data only -> dm_gnt. Fetch only -> if_gnt. Both: dm_gnt, unless starve_cnt==MAX_STARVE -> if_gnt.
//    Never both grants in one cycle. No request -> no grant, ram_wren=0, ram_addr=if_addr (don't care).
//  - RAM mux: the granted requester drives ram_addr.
//    ram_wren = dm_gnt & dm_we. ram_byteena = dm_be when writing, else all ones. ram_data = dm_wdata.
//  - rd_owner register: next = IF if if_gnt; DM if dm_gnt & ~dm_we; else NONE.
//  - Read return: if_rvalid=(rd_owner==IF), dm_rvalid=(rd_owner==DM).
//    Both rdata outputs are driven from ram_q and are valid only when the matching rvalid=1.
//  - Writes: ram_wren asserts in the grant cycle; no rvalid is produced.
//    A read of the same address in the next cycle returns the new data.
//  - starve_cnt: increments (saturating at MAX_STARVE) when if_req & ~if_gnt. Clears on if_gnt or ~if_req.
//  - Back-to-back: a new grant is allowed every cycle, including the cycle in which rvalid of the prior read asserts.
//  - Requests dropped before their grant are legal. Dropping a request after its grant has no effect on rvalid.
//  - fetch_stall is combinational. The pipeline control must freeze PC and the FD register in any cycle where it is 1.
// STRUCTURE
//  - Shared package kanade32_pkg:
//    localparam OWNER_NONE/OWNER_IF/OWNER_DM (2-bit enum type owner_t);
//    RAM_ADDR_W=30 and DATA_W=32 constants.
//  - Single flat module; no sub-module. The arbitration comb block and the state regs (rd_owner, starve_cnt) stay local.
// TESTING
//  1 Reset: hold reset_n=0 with if_req=dm_req=1 -> if_gnt=dm_gnt=0, rvalids 0 the following cycle.
//  2 Fetch only, if_addr=0..3 consecutive -> if_gnt=1 each cycle; if_rvalid=1 from cycle 2; if_rdata=mem[0..3] in order; fetch_stall=0.
//  3 Store: dm_we=1, addr=0x10, wdata=0xDEADBEEF, be=4'b0011; then read 0x10 (old 0) -> dm_rdata=0x0000BEEF; no dm_rvalid for the store.
//  4 Contention: if_req and dm_req (reads) held 8 cycles, MAX_STARVE=3 -> grants DM,DM,DM,IF repeating; fetch_stall=1 exactly on DM-grant cycles.
//  5 Owner routing: alternate IF read 0x4 / DM read 0x8 -> each rvalid only on its own port, with the correct word; never both rvalids high.
//  6 Reset mid-read: grant IF read, assert reset_n=0 the next edge -> if_rvalid stays 0; starve_cnt=0 after reset.

Source files
------------

// File: rtl/kanade32_pkg.sv
// Shared types and constants for the kanade32 core memory subsystem.
package kanade32_pkg;

  localparam int RAM_ADDR_W     = 30;
  localparam int DATA_W         = 32;
  localparam int MAX_STARVE_DEF = 3;

  // Which requester owns the read data returning from the RAM this cycle.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_DM   = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store.
// Data normally wins; fetch wins once after MAX_STARVE consecutive denials.
// Read data is routed back one cycle after the grant using a registered owner tag.
module mem_port_arbiter #(
  parameter int ADDR_W     = kanade32_pkg::RAM_ADDR_W,
  parameter int DATA_W     = kanade32_pkg::DATA_W,
  parameter int MAX_STARVE = kanade32_pkg::MAX_STARVE_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_wren,
  output logic [DATA_W/8-1:0] ram_byteena,
  output logic [DATA_W-1:0]   ram_data,
  input  logic [DATA_W-1:0]   ram_q,
  output logic                fetch_stall
);

  import kanade32_pkg::*;

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STARVE);

  owner_t           r_rd_owner;
  owner_t           w_rd_owner_next;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_cnt_next;
  logic             w_if_gnt;
  logic             w_dm_gnt;
  logic             w_starved;

  assign w_starved = (r_starve_cnt == CNT_MAX);

  // Grant selection: data has priority unless fetch has been starved long enough.
  always_comb begin
    w_if_gnt = 1'b0;
    w_dm_gnt = 1'b0;
    if (reset_n) begin
      if (dm_req && !(if_req && w_starved)) begin
        w_dm_gnt = 1'b1;
      end else if (if_req) begin
        w_if_gnt = 1'b1;
      end
    end
  end

  // Next owner tag and starvation count derived from this cycle's grant.
  always_comb begin
    w_rd_owner_next   = OWNER_NONE;
    w_starve_cnt_next = '0;
    if (w_if_gnt) begin
      w_rd_owner_next = OWNER_IF;
    end else if (w_dm_gnt && !dm_we) begin
      w_rd_owner_next = OWNER_DM;
    end
    if (if_req && !w_if_gnt) begin
      w_starve_cnt_next = w_starved ? r_starve_cnt : r_starve_cnt + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_owner   <= OWNER_NONE;
      r_starve_cnt <= '0;
    end else begin
      r_rd_owner   <= w_rd_owner_next;
      r_starve_cnt <= w_starve_cnt_next;
    end
  end

  assign if_gnt      = w_if_gnt;
  assign dm_gnt      = w_dm_gnt;
  assign fetch_stall = if_req & ~w_if_gnt;

  // The granted requester drives the RAM; fetch address is the idle default.
  assign ram_addr    = w_dm_gnt ? dm_addr : if_addr;
  assign ram_wren    = w_dm_gnt & dm_we;
  assign ram_byteena = ram_wren ? dm_be : {BE_W{1'b1}};
  assign ram_data    = dm_wdata;

  // Both ports see the RAM output; the owner tag says whose it is.
  assign if_rvalid = (r_rd_owner == OWNER_IF);
  assign dm_rvalid = (r_rd_owner == OWNER_DM);
  assign if_rdata  = ram_q;
  assign dm_rdata  = ram_q;

endmodule
